// File: rtl/tetris_key_pkg.sv
// Shared constants and channel state encoding for the pushbutton front end.
package tetris_key_pkg;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_ROT   = 2;
  localparam int KEY_DROP  = 3;

  localparam int CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  // The debounced level is high while the key is accepted as down, including its release window.
  function automatic logic state_is_down(input key_state_e st);
    return (st == ST_PRESSED) || (st == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key bundle between the raw buttons and the debounced consumers.
// KEY_PRESS_PULSE_EN adds the one-cycle press strobe.
interface key_debounce_if #(
  parameter int NUM_KEYS = 4
);
  import tetris_key_pkg::*;

  logic [NUM_KEYS-1:0] key_raw_n;
  logic [NUM_KEYS-1:0] key_level;
`ifdef KEY_PRESS_PULSE_EN
  logic [NUM_KEYS-1:0] key_press;

  modport master (output key_raw_n, input key_level, input key_press);
  modport slave  (input key_raw_n, output key_level, output key_press);
`else
  modport master (output key_raw_n, input key_level);
  modport slave  (input key_raw_n, output key_level);
`endif

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, debounce FSM with stability counter, registered level.
// KEY_PRESS_PULSE_EN adds a press strobe aligned with the level rise.
module key_debounce_ch
  import tetris_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic RST,
  input  logic key_raw_n_i,
`ifdef KEY_PRESS_PULSE_EN
  output logic key_press_o,
`endif
  output logic key_level_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_pressed;
  key_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw_n_i};
    end
  end

  assign s_pressed = ~sync_q[SYNC_STAGES-1];

  // Any opposite sample in a wait state drops back and clears the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RELEASED: begin
        if (s_pressed) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_RELEASED;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s_pressed) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!s_pressed) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_PRESSED;
        end
      end
      ST_RELEASE_WAIT: begin
        if (s_pressed) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
    level_d = state_is_down(state_d);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign key_level_o = level_q;

`ifdef KEY_PRESS_PULSE_EN
  logic press_q, press_d;

  assign press_d = (state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      press_q <= 1'b0;
    end else begin
      press_q <= press_d;
    end
  end

  assign key_press_o = press_q;
`endif

endmodule

// File: rtl/key_debounce.sv
// Pushbutton front end: NUM_KEYS independent debounce channels behind one key interface.
// KEY_PRESS_PULSE_EN enables the per-key press strobe output.
module key_debounce
  import tetris_key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic           clk,
  input  logic           RST,
  key_debounce_if.slave  kif
);

  logic [NUM_KEYS-1:0] level_s;
`ifdef KEY_PRESS_PULSE_EN
  logic [NUM_KEYS-1:0] press_s;
`endif

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .clk         (clk),
      .RST         (RST),
      .key_raw_n_i (kif.key_raw_n[g]),
`ifdef KEY_PRESS_PULSE_EN
      .key_press_o (press_s[g]),
`endif
      .key_level_o (level_s[g])
    );
  end

  assign kif.key_level = level_s;
`ifdef KEY_PRESS_PULSE_EN
  assign kif.key_press = press_s;
`endif

endmodule
